// File: rtl/gpu_bg_block_buffer.sv
// gpu_bg_block_buffer: one-block BG write-back buffer with DDR load/save FSM, dirty mask and flush.
module gpu_bg_block_buffer #(
  parameter int LANES     = 2,
  parameter int BLOCK_PIX = 16,
  parameter int PIX_W     = 16,
  parameter int ADR_W     = 15,
  parameter int SLOT_W    = (BLOCK_PIX / LANES > 1) ? $clog2(BLOCK_PIX / LANES) : 1
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic                       i_blendEnable,
  input  logic                       i_pixValid,
  input  logic [ADR_W-1:0]           i_pixAdr,
  input  logic [SLOT_W-1:0]          i_pixSlot,
  input  logic [LANES-1:0]           i_pixSel,
  input  logic [LANES*PIX_W-1:0]     i_pixData,
  output logic                       o_pixReady,
  output logic [LANES*PIX_W-1:0]     o_bgRead,
  input  logic                       i_flush,
  output logic                       o_flushDone,
  output logic                       o_loadReq,
  output logic [ADR_W-1:0]           o_loadAdr,
  input  logic                       i_loadAck,
  input  logic [BLOCK_PIX*PIX_W-1:0] i_loadData,
  output logic                       o_saveReq,
  output logic [ADR_W-1:0]           o_saveAdr,
  output logic [BLOCK_PIX*PIX_W-1:0] o_saveData,
  output logic [BLOCK_PIX-1:0]       o_saveMask,
  input  logic                       i_saveAck,
  output logic                       o_busy
);
  localparam int GW     = LANES * PIX_W;
  localparam int GROUPS = BLOCK_PIX / LANES;

  typedef enum logic [1:0] {EMPTY, RESIDENT, SAVE, LOAD} state_t;

  state_t                     state_q, state_d;
  logic [BLOCK_PIX*PIX_W-1:0] pix_buf_q, pix_buf_d;
  logic [BLOCK_PIX-1:0]       dirty_q, dirty_d;
  logic [ADR_W-1:0]           cur_adr_q, cur_adr_d, pend_adr_q, pend_adr_d;
  logic                       flush_tag_q, flush_tag_d, flush_done_q, flush_done_d;
  logic                       hit, accept;
  int                         slot;

  always_comb begin
    slot   = int'(i_pixSlot) % GROUPS;
    hit    = state_q == RESIDENT && i_pixAdr == cur_adr_q;
    accept = i_pixValid && hit && !i_flush;
  end

  assign o_pixReady  = hit && !i_flush;
  assign o_bgRead    = pix_buf_q[slot*GW +: GW];
  assign o_flushDone = flush_done_q;
  assign o_loadReq   = state_q == LOAD;
  assign o_loadAdr   = cur_adr_q;
  assign o_saveReq   = state_q == SAVE;
  assign o_saveAdr   = cur_adr_q;
  assign o_saveData  = pix_buf_q;
  assign o_saveMask  = dirty_q;
  assign o_busy      = state_q == SAVE || state_q == LOAD;

  always_comb begin
    state_d      = state_q;
    pix_buf_d    = pix_buf_q;
    dirty_d      = dirty_q;
    cur_adr_d    = cur_adr_q;
    pend_adr_d   = pend_adr_q;
    flush_tag_d  = flush_tag_q;
    flush_done_d = 1'b0;
    for (int k = 0; k < LANES; k++)
      if (accept && i_pixSel[k]) begin
        pix_buf_d[(slot*LANES+k)*PIX_W +: PIX_W] = i_pixData[k*PIX_W +: PIX_W];
        dirty_d[slot*LANES+k] = 1'b1;
      end
    case (state_q)
      EMPTY, RESIDENT: begin
        // a flush still held during its own done cycle is the same request, not a new one
        if (i_flush) begin
          if (!flush_done_q) begin
            if (dirty_q != '0) begin
              state_d     = SAVE;
              flush_tag_d = 1'b1;
            end else begin
              state_d      = EMPTY;
              flush_done_d = 1'b1;
            end
          end
        end else if (i_pixValid && !hit) begin
          if (state_q == RESIDENT && dirty_q != '0) begin
            state_d     = SAVE;
            flush_tag_d = 1'b0;
            pend_adr_d  = i_pixAdr;
          end else begin
            cur_adr_d = i_pixAdr;
            dirty_d   = '0;
            state_d   = i_blendEnable ? LOAD : RESIDENT;
          end
        end
      end
      SAVE: begin
        if (i_saveAck) begin
          dirty_d      = '0;
          flush_done_d = flush_tag_q;
          cur_adr_d    = flush_tag_q ? cur_adr_q : pend_adr_q;
          state_d      = flush_tag_q ? EMPTY : (i_blendEnable ? LOAD : RESIDENT);
        end
      end
      LOAD: begin
        if (i_loadAck) begin
          pix_buf_d = i_loadData;
          state_d   = RESIDENT;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q      <= EMPTY;
      dirty_q      <= '0;
      cur_adr_q    <= '0;
      pend_adr_q   <= '0;
      flush_tag_q  <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dirty_q      <= dirty_d;
      cur_adr_q    <= cur_adr_d;
      pend_adr_q   <= pend_adr_d;
      flush_tag_q  <= flush_tag_d;
      flush_done_q <= flush_done_d;
    end
  end

  always_ff @(posedge clk) pix_buf_q <= pix_buf_d;
endmodule
